// File: rtl/sd_decimator.sv
// Third-order CIC decimator for a 2-bit sigma-delta bitstream.
// Decodes each valid symbol to +1/-1/0, runs three wrap-around integrators,
// decimates by DECIM and then applies three differential-delay-1 combs.
// The result is presented on a valid/ready output register.
// Optional feature macro: SD_DECIM_OVR_EN. When defined, a result arriving
// while the held sample is stalled is dropped and the sticky overrun flag is set.
// When undefined, the new result overwrites the held sample and overrun stays 0.
module sd_decimator #(
  parameter int DECIM     = 64,
  parameter int LOG2DECIM = 6,
  parameter int OUTWIDTH  = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          bs_in,
  input  logic                bs_valid,
  output logic [OUTWIDTH-1:0] sample_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun,
  input  logic                clr_ovr
);

  logic [OUTWIDTH-1:0]  w_sym;
  logic [OUTWIDTH-1:0]  w_i1Next;
  logic [OUTWIDTH-1:0]  w_i2Next;
  logic [OUTWIDTH-1:0]  w_i3Next;
  logic [OUTWIDTH-1:0]  w_c1;
  logic [OUTWIDTH-1:0]  w_c2;
  logic [OUTWIDTH-1:0]  w_c3;
  logic                 w_tick;
  logic                 w_canLoad;

  logic [OUTWIDTH-1:0]  r_i1;
  logic [OUTWIDTH-1:0]  r_i2;
  logic [OUTWIDTH-1:0]  r_i3;
  logic [LOG2DECIM-1:0] r_phase;
  logic [OUTWIDTH-1:0]  r_dec;
  logic                 r_combEn;
  logic [OUTWIDTH-1:0]  r_d1;
  logic [OUTWIDTH-1:0]  r_d2;
  logic [OUTWIDTH-1:0]  r_d3;
  logic [OUTWIDTH-1:0]  r_combRes;
  logic                 r_resValid;
  logic [OUTWIDTH-1:0]  r_sample;
  logic                 r_outValid;
  logic                 r_overrun;

  // Symbol decode, integrator next-values, comb arithmetic and tick detect.
  always_comb begin
    w_sym = '0;
    if (bs_in == 2'b01) begin
      w_sym = OUTWIDTH'(1);
    end else if (bs_in == 2'b10) begin
      w_sym = {OUTWIDTH{1'b1}};
    end
    w_i1Next = r_i1 + w_sym;
    w_i2Next = r_i2 + w_i1Next;
    w_i3Next = r_i3 + w_i2Next;
    w_c1     = r_dec - r_d1;
    w_c2     = w_c1 - r_d2;
    w_c3     = w_c2 - r_d3;
    w_tick   = bs_valid && (r_phase == LOG2DECIM'(DECIM - 1));
  end

  // Integrators and phase counter advance only on valid symbols.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_i1    <= '0;
      r_i2    <= '0;
      r_i3    <= '0;
      r_phase <= '0;
    end else if (bs_valid) begin
      r_i1    <= w_i1Next;
      r_i2    <= w_i2Next;
      r_i3    <= w_i3Next;
      r_phase <= r_phase + 1'b1;
    end
  end

  // On a tick, capture the third integrator (including the tick symbol) and arm the combs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dec    <= '0;
      r_combEn <= 1'b0;
    end else begin
      r_combEn <= w_tick;
      if (w_tick) begin
        r_dec <= w_i3Next;
      end
    end
  end

  // Comb stage: one update per decimated sample, result registered for the output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d1       <= '0;
      r_d2       <= '0;
      r_d3       <= '0;
      r_combRes  <= '0;
      r_resValid <= 1'b0;
    end else begin
      r_resValid <= r_combEn;
      if (r_combEn) begin
        r_d1      <= r_dec;
        r_d2      <= w_c1;
        r_d3      <= w_c2;
        r_combRes <= w_c3;
      end
    end
  end

`ifdef SD_DECIM_OVR_EN
  assign w_canLoad = !r_outValid || out_ready;

  // Sticky overrun: set when a result is dropped, a coincident clear loses to the new event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= (r_resValid && !w_canLoad) || (r_overrun && !clr_ovr);
    end
  end
`else
  logic w_unused_clr;
  assign w_canLoad    = 1'b1;
  assign w_unused_clr = clr_ovr;

  // Without overrun detection the flag is held at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
    end
  end
`endif

  // Output register with valid/ready handshake; a transfer and a new load may share an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample   <= '0;
      r_outValid <= 1'b0;
    end else begin
      if (r_resValid && w_canLoad) begin
        r_sample   <= r_combRes;
        r_outValid <= 1'b1;
      end else if (r_outValid && out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign sample_out = r_sample;
  assign out_valid  = r_outValid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_sd_decimator.sv
// Directed testbench for sd_decimator with hand-computed CIC sample values.
// Expected behaviour of the overrun feature follows SD_DECIM_OVR_EN.
module tb_sd_decimator;

  localparam int OW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    bs_in;
  logic          bs_valid;
  logic [OW-1:0] sample_out;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;
  logic          clr_ovr;

  int            checks = 0;
  int            failures = 0;
  int            stimMode;
  logic [1:0]    stimSym;
  int            stepCnt;
  int            symCnt;

  sd_decimator #(.DECIM(64), .LOG2DECIM(6), .OUTWIDTH(OW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bs_in      (bs_in),
    .bs_valid   (bs_valid),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Drive one symbol per the current stimulus mode, then advance past the next rising edge.
  task automatic stepCycle();
    case (stimMode)
      0: begin
        bs_valid = 1'b1;
        bs_in    = stimSym;
      end
      1: begin
        bs_valid = 1'b1;
        bs_in    = (symCnt % 2 == 0) ? 2'b01 : 2'b10;
      end
      default: begin
        bs_valid = (stepCnt % 2 == 0);
        bs_in    = 2'b01;
      end
    endcase
    if (bs_valid) symCnt++;
    stepCnt++;
    @(posedge clk);
    #1;
  endtask

  // Reset the DUT for one edge and arm a new stimulus run.
  task automatic startRun(input int mode, input logic [1:0] sym);
    reset     = 1'b0;
    bs_valid  = 1'b0;
    bs_in     = 2'b00;
    out_ready = 1'b1;
    clr_ovr   = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    stimMode = mode;
    stimSym  = sym;
    stepCnt  = 0;
    symCnt   = 0;
  endtask

  // Step until out_valid is seen; steps = -1 when the cycle budget expires.
  task automatic waitSample(output logic [OW-1:0] val, output int steps);
    steps = 0;
    val   = '0;
    for (int i = 0; i < 300; i++) begin
      stepCycle();
      steps++;
      if (out_valid === 1'b1) begin
        val = sample_out;
        return;
      end
    end
    steps = -1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bs_valid  = 1'b0;
    bs_in     = 2'b00;
    out_ready = 1'b1;
    clr_ovr   = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (sample_out !== '0) begin
      failures++;
      $display("[TB] FAIL reset_sample: got %0d expected 0", sample_out);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_overrun: got %b expected 0", overrun);
    end
  endtask

  task automatic test_zero();
    logic [OW-1:0] v;
    int s;
    startRun(0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      waitSample(v, s);
      checks++;
      if (s != ((i == 0) ? 66 : 64)) begin
        failures++;
        $display("[TB] FAIL zero_spacing%0d: got %0d expected %0d", i, s, (i == 0) ? 66 : 64);
      end
      checks++;
      if (v !== '0) begin
        failures++;
        $display("[TB] FAIL zero_value%0d: got %0d expected 0", i, $signed(v));
      end
    end
  endtask

  task automatic test_plus();
    int expVal[5]   = '{45760, 220480, 262144, 262144, 262144};
    int expSteps[5] = '{66, 64, 64, 64, 64};
    logic [OW-1:0] v;
    int s;
    startRun(0, 2'b01);
    for (int i = 0; i < 5; i++) begin
      waitSample(v, s);
      checks++;
      if (s != expSteps[i]) begin
        failures++;
        $display("[TB] FAIL plus_spacing%0d: got %0d expected %0d", i, s, expSteps[i]);
      end
      checks++;
      if (v !== OW'(expVal[i])) begin
        failures++;
        $display("[TB] FAIL plus_value%0d: got %0d expected %0d", i, $signed(v), expVal[i]);
      end
    end
  endtask

  task automatic test_minus();
    logic [OW-1:0] v;
    int s;
    startRun(0, 2'b10);
    for (int i = 0; i < 5; i++) begin
      waitSample(v, s);
      checks++;
      if (s != ((i == 0) ? 66 : 64)) begin
        failures++;
        $display("[TB] FAIL minus_spacing%0d: got %0d expected %0d", i, s, (i == 0) ? 66 : 64);
      end
      if (i >= 3) begin
        checks++;
        if (v !== OW'(-262144)) begin
          failures++;
          $display("[TB] FAIL minus_value%0d: got %0d expected -262144", i, $signed(v));
        end
      end
    end
  endtask

  task automatic test_alternate();
    logic [OW-1:0] v;
    int s;
    startRun(1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      waitSample(v, s);
      checks++;
      if (s != ((i == 0) ? 66 : 64)) begin
        failures++;
        $display("[TB] FAIL alt_spacing%0d: got %0d expected %0d", i, s, (i == 0) ? 66 : 64);
      end
      if (i >= 3) begin
        checks++;
        if (v !== '0) begin
          failures++;
          $display("[TB] FAIL alt_value%0d: got %0d expected 0", i, $signed(v));
        end
      end
    end
  endtask

  task automatic test_half_rate();
    logic [OW-1:0] v;
    int s;
    startRun(2, 2'b01);
    for (int i = 0; i < 5; i++) begin
      waitSample(v, s);
      checks++;
      if (s != ((i == 0) ? 129 : 128)) begin
        failures++;
        $display("[TB] FAIL half_spacing%0d: got %0d expected %0d", i, s, (i == 0) ? 129 : 128);
      end
      if (i >= 3) begin
        checks++;
        if (v !== OW'(262144)) begin
          failures++;
          $display("[TB] FAIL half_value%0d: got %0d expected 262144", i, $signed(v));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] expHeld;
    logic          expOvr;
`ifdef SD_DECIM_OVR_EN
    expHeld = OW'(45760);
    expOvr  = 1'b1;
`else
    expHeld = OW'(220480);
    expOvr  = 1'b0;
`endif
    startRun(0, 2'b01);
    out_ready = 1'b0;
    for (int i = 0; i < 66; i++) stepCycle();
    checks++;
    if (out_valid !== 1'b1 || sample_out !== OW'(45760)) begin
      failures++;
      $display("[TB] FAIL bp_first: got valid=%b value=%0d expected valid=1 value=45760", out_valid, $signed(sample_out));
    end
    for (int i = 0; i < 34; i++) stepCycle();
    checks++;
    if (out_valid !== 1'b1 || sample_out !== OW'(45760)) begin
      failures++;
      $display("[TB] FAIL bp_stable: got valid=%b value=%0d expected valid=1 value=45760", out_valid, $signed(sample_out));
    end
    for (int i = 0; i < 31; i++) stepCycle();
    checks++;
    if (sample_out !== expHeld || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_second: got valid=%b value=%0d expected valid=1 value=%0d", out_valid, $signed(sample_out), $signed(expHeld));
    end
    checks++;
    if (overrun !== expOvr) begin
      failures++;
      $display("[TB] FAIL bp_overrun: got %b expected %b", overrun, expOvr);
    end
    clr_ovr = 1'b1;
    stepCycle();
    clr_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_clear: got %b expected 0", overrun);
    end
    out_ready = 1'b1;
    stepCycle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_mid_reset();
    logic [OW-1:0] v;
    int s;
    startRun(0, 2'b01);
    out_ready = 1'b0;
    for (int i = 0; i < 94; i++) stepCycle();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_pre_valid: got %b expected 1", out_valid);
    end
    reset = 1'b0;
    #2;
    checks++;
    if (sample_out !== '0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs: got value=%0d valid=%b ovr=%b expected 0/0/0", $signed(sample_out), out_valid, overrun);
    end
    @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    stepCnt   = 0;
    symCnt    = 0;
    waitSample(v, s);
    checks++;
    if (s != 66) begin
      failures++;
      $display("[TB] FAIL mid_latency: got %0d expected 66", s);
    end
    checks++;
    if (v !== OW'(45760)) begin
      failures++;
      $display("[TB] FAIL mid_value: got %0d expected 45760", $signed(v));
    end
  endtask

  // Run every scenario in order and print the summary.
  initial begin
    stimMode = 0;
    stimSym  = 2'b00;
    stepCnt  = 0;
    symCnt   = 0;
    test_reset();
    test_zero();
    test_plus();
    test_minus();
    test_alternate();
    test_half_rate();
    test_backpressure();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
